seg_capture: RTL and testbench
==============================

SEG_CAPTURE -- requirements
Module: seg_capture

Interface
REQ-001 The block SHALL have one clock and one reset: the clock port SHALL be named clk, and reset SHALL be asynchronous and active-low, on a port named rst_n.
REQ-002 Parameter STABLE_CYCLES SHALL default to 4; it is the number of consecutive identical synchronised samples required to accept a sample (range 1..255).
REQ-003 Parameter TIMEOUT SHALL default to 4096; it is the number of cycles without an accepted sample before the stale flag is raised.
REQ-004 Port clk SHALL be an input, 1 bit: the system clock.
REQ-005 Port rst_n SHALL be an input, 1 bit: asynchronous active-low reset.
REQ-006 Port digits SHALL be an input, 4 bits: multiplexed digit enables, active-low one-hot, bit i selects position i.
REQ-007 Port segments SHALL be an input, 8 bits: active-high segments, bit0=A through bit6=G, bit7=DP.
REQ-008 Port value SHALL be an output, 16 bits: decoded codes, with position i in value[4i+3:4i].
REQ-009 Port dp SHALL be an output, 4 bits: captured DP bit per position.
REQ-010 Port frame_valid SHALL be an output, 1 bit: a one-cycle pulse when all four positions have been captured.
REQ-011 Port bad_code SHALL be an output, 1 bit: a one-cycle pulse when an accepted segment pattern is not recognised.
REQ-012 Port stale SHALL be an output, 1 bit: high when no sample has been accepted for TIMEOUT cycles.

Function
REQ-013 digits and segments SHALL pass through a 2-flop synchroniser before any other logic.
REQ-014 A synchronised sample SHALL be well-formed only when digits contains exactly one 0; 4'b1111 (blanking) and multi-zero patterns SHALL never be accepted.
REQ-015 A stability counter SHALL reset to 0 when the synchronised {digits,segments} differs from the previous cycle, and SHALL increment (saturating) otherwise.
REQ-016 A well-formed sample SHALL be accepted exactly once per hold period, on the cycle the counter reaches STABLE_CYCLES-1; it SHALL re-arm only after the inputs change.
REQ-017 Latency: with inputs changed before edge k and held, the updated value/dp SHALL be visible after edge k+2+STABLE_CYCLES.
REQ-018 The decode SHALL use segments[6:0] as follows:
- 0x3F->0, 0x06->1, 0x5B->2, 0x4F->3, 0x66->4, 0x6D->5, 0x7D->6, 0x07->7, 0x7F->8, 0x6F->9;
- 0x00->4'hF (blank);
- any other pattern->4'hE, and bad_code SHALL pulse in the same cycle as the write.
REQ-019 On accept: value nibble i SHALL take the decoded code, dp[i] SHALL take segments[7], and seen[i] SHALL be set to 1.
REQ-020 frame_valid SHALL pulse on the accept that makes seen==4'b1111, with value already holding the new nibble; seen SHALL clear to 0 in the same cycle.
REQ-021 A repeat accept of an already-seen position SHALL overwrite that position's nibble and SHALL NOT change seen.
REQ-022 The idle counter SHALL clear on every accept, and SHALL otherwise increment, saturating at TIMEOUT.
REQ-023 stale SHALL assert when the idle counter reaches TIMEOUT and SHALL deassert in the cycle after the next accept.
REQ-024 Simultaneous bad_code and frame_valid SHALL both pulse.

Reset
REQ-025 On rst_n low, the block SHALL reset as follows:
- synchronisers, stability counter, idle counter and seen SHALL clear to 0;
- value SHALL be 16'hFFFF;
- dp, frame_valid, bad_code and stale SHALL be 0;
- armed SHALL be 1.
REQ-026 Reset asserted mid-frame SHALL discard partial captures; the first frame_valid after release SHALL require four fresh accepts.

Structure
REQ-027 A shared package SHALL hold the segment encoding constants SEG_0..SEG_9, the codes CODE_BLANK=4'hF and CODE_BAD=4'hE, and the bit-index constants.
REQ-028 Combinational decoding SHALL be placed in a sub-module seg_decode (segments[6:0] -> 4-bit code, bad flag).

Verification
REQ-029 digits=4'b1110, segments=0x4F held 10 cycles -> value[3:0]=3, dp[0]=0, no bad_code.
REQ-030 A scan with positions 0..3 = 0x4F, 0x4F, 0x7D, 0x4F, each held 256 cycles -> value=16'h3633, one frame_valid pulse per full scan.
REQ-031 segments=0x06 held 2 cycles then 0x5B, STABLE_CYCLES=4 -> only 2 is captured.
REQ-032 segments=0x49 on position 2 -> value[11:8]=4'hE with a single bad_code pulse; digits=4'b1100 held -> no change.
REQ-033 Inputs frozen at 4'b1111 -> stale=1 after 4096 cycles; the next valid accept clears it.
REQ-034 rst_n pulsed after 3 positions are captured -> value=16'hFFFF, and frame_valid occurs only after 4 new accepts.

Source files
------------

// File: rtl/seg_capture_pkg.sv
// Shared constants and helpers for the seven-segment display capture block:
// segment encodings, decoded codes, bit positions and digit-select helpers.
package seg_capture_pkg;

    localparam int NUM_POS    = 4;
    localparam int CODE_W     = 4;
    localparam int SEG_W      = 8;
    localparam int SEG_A_BIT  = 0;
    localparam int SEG_G_BIT  = 6;
    localparam int SEG_DP_BIT = 7;

    localparam logic [SEG_G_BIT:0] SEG_BLANK = 7'h00;
    localparam logic [SEG_G_BIT:0] SEG_0     = 7'h3F;
    localparam logic [SEG_G_BIT:0] SEG_1     = 7'h06;
    localparam logic [SEG_G_BIT:0] SEG_2     = 7'h5B;
    localparam logic [SEG_G_BIT:0] SEG_3     = 7'h4F;
    localparam logic [SEG_G_BIT:0] SEG_4     = 7'h66;
    localparam logic [SEG_G_BIT:0] SEG_5     = 7'h6D;
    localparam logic [SEG_G_BIT:0] SEG_6     = 7'h7D;
    localparam logic [SEG_G_BIT:0] SEG_7     = 7'h07;
    localparam logic [SEG_G_BIT:0] SEG_8     = 7'h7F;
    localparam logic [SEG_G_BIT:0] SEG_9     = 7'h6F;

    localparam logic [CODE_W-1:0] CODE_BLANK = 4'hF;
    localparam logic [CODE_W-1:0] CODE_BAD   = 4'hE;

    typedef struct packed {
        logic [NUM_POS-1:0] digits;
        logic [SEG_W-1:0]   segments;
    } sample_t;

    // Digit enables are active-low, so a legal select has exactly one zero bit.
    function automatic logic is_one_cold(input logic [NUM_POS-1:0] d);
        logic ok;
        case (d)
            4'b1110, 4'b1101, 4'b1011, 4'b0111: ok = 1'b1;
            default:                            ok = 1'b0;
        endcase
        return ok;
    endfunction

    function automatic logic [1:0] cold_index(input logic [NUM_POS-1:0] d);
        logic [1:0] idx;
        idx = 2'd0;
        for (int i = 0; i < NUM_POS; i++) begin
            if (!d[i]) idx = 2'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/seg_capture_decode.sv
// Combinational seven-segment pattern decoder: maps segments A..G to a
// 4-bit digit code, flagging any pattern that is neither a digit nor blank.
module seg_decode
    import seg_capture_pkg::*;
(
    input  logic [SEG_G_BIT:0] seg,
    output logic [CODE_W-1:0]  code,
    output logic               bad
);

    always_comb begin
        code = CODE_BAD;
        bad  = 1'b1;
        case (seg)
            SEG_0:     begin code = 4'd0;       bad = 1'b0; end
            SEG_1:     begin code = 4'd1;       bad = 1'b0; end
            SEG_2:     begin code = 4'd2;       bad = 1'b0; end
            SEG_3:     begin code = 4'd3;       bad = 1'b0; end
            SEG_4:     begin code = 4'd4;       bad = 1'b0; end
            SEG_5:     begin code = 4'd5;       bad = 1'b0; end
            SEG_6:     begin code = 4'd6;       bad = 1'b0; end
            SEG_7:     begin code = 4'd7;       bad = 1'b0; end
            SEG_8:     begin code = 4'd8;       bad = 1'b0; end
            SEG_9:     begin code = 4'd9;       bad = 1'b0; end
            SEG_BLANK: begin code = CODE_BLANK; bad = 1'b0; end
            default:   begin code = CODE_BAD;   bad = 1'b1; end
        endcase
    end

endmodule

// File: rtl/seg_capture.sv
// Captures a multiplexed four-digit seven-segment display: synchronises the
// drive lines, debounces each digit slot and assembles decoded frames.
module seg_capture
    import seg_capture_pkg::*;
#(
    parameter int STABLE_CYCLES = 4,
    parameter int TIMEOUT       = 4096
)
(
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_POS-1:0]         digits,
    input  logic [SEG_W-1:0]           segments,
    output logic [NUM_POS*CODE_W-1:0]  value,
    output logic [NUM_POS-1:0]         dp,
    output logic                       frame_valid,
    output logic                       bad_code,
    output logic                       stale
);

    localparam int              IDLE_W      = $clog2(TIMEOUT + 1);
    localparam logic [7:0]      STABLE_LAST = 8'(STABLE_CYCLES - 1);
    localparam logic [IDLE_W-1:0] IDLE_MAX  = IDLE_W'(TIMEOUT);

    sample_t             sync1;
    sample_t             sync2;
    sample_t             prev;
    logic [7:0]          stable_cnt;
    logic                armed;
    logic [IDLE_W-1:0]   idle_cnt;
    logic [IDLE_W-1:0]   idle_next;
    logic [NUM_POS-1:0]  seen;
    logic [NUM_POS-1:0]  seen_next;
    logic                changed;
    logic                well_formed;
    logic                accept;
    logic [1:0]          pos;
    logic [CODE_W-1:0]   dec_code;
    logic                dec_bad;

    seg_decode u_decode (
        .seg  (sync2.segments[SEG_G_BIT:0]),
        .code (dec_code),
        .bad  (dec_bad)
    );

    assign changed     = (sync2 != prev);
    assign well_formed = is_one_cold(sync2.digits);
    assign pos         = cold_index(sync2.digits);
    assign accept      = armed && !changed && well_formed && (stable_cnt == STABLE_LAST);
    assign seen_next   = seen | ~sync2.digits;
    assign idle_next   = accept ? '0 :
                         (idle_cnt == IDLE_MAX) ? idle_cnt : idle_cnt + 1'b1;

    // Two-flop synchroniser plus the hold-time counter; armed guarantees a
    // single accept per hold, and only a change of the sample re-arms it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1      <= '0;
            sync2      <= '0;
            prev       <= '0;
            stable_cnt <= '0;
            armed      <= 1'b1;
        end else begin
            sync1.digits   <= digits;
            sync1.segments <= segments;
            sync2          <= sync1;
            prev           <= sync2;
            if (changed) begin
                stable_cnt <= '0;
                armed      <= 1'b1;
            end else begin
                if (stable_cnt != 8'hFF) stable_cnt <= stable_cnt + 8'd1;
                if (accept) armed <= 1'b0;
            end
        end
    end

    // Frame assembly: completion is detected on seen_next so the pulse lines
    // up with the write of the last nibble.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            value       <= '1;
            dp          <= '0;
            seen        <= '0;
            frame_valid <= 1'b0;
            bad_code    <= 1'b0;
        end else begin
            frame_valid <= 1'b0;
            bad_code    <= 1'b0;
            if (accept) begin
                value[{pos, 2'b00} +: CODE_W] <= dec_code;
                dp[pos]                       <= sync2.segments[SEG_DP_BIT];
                bad_code                      <= dec_bad;
                if (seen_next == '1) begin
                    frame_valid <= 1'b1;
                    seen        <= '0;
                end else begin
                    seen <= seen_next;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idle_cnt <= '0;
            stale    <= 1'b0;
        end else begin
            idle_cnt <= idle_next;
            stale    <= (idle_next == IDLE_MAX);
        end
    end

endmodule

// File: tb/tb_seg_capture.sv
// Scoreboard bench for seg_capture: directed display scans with hand-worked
// expected frames, pulses checked by an independent monitor.
module tb_seg_capture;

    logic        clk;
    logic        rst_n;
    logic [3:0]  digits;
    logic [7:0]  segments;
    logic [15:0] value;
    logic [3:0]  dp;
    logic        frame_valid;
    logic        bad_code;
    logic        stale;

    typedef struct packed {
        logic [15:0] value;
        logic [3:0]  dp;
        logic        frame;
        logic        bad;
    } exp_t;

    exp_t sb[$];
    int   total_cnt = 0;
    int   bad_cnt   = 0;

    seg_capture #(.STABLE_CYCLES(4), .TIMEOUT(4096)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .digits      (digits),
        .segments    (segments),
        .value       (value),
        .dp          (dp),
        .frame_valid (frame_valid),
        .bad_code    (bad_code),
        .stale       (stale)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Every frame_valid/bad_code pulse must match the next queued expectation.
    always @(negedge clk) begin : monitor
        exp_t got;
        exp_t want;
        if (rst_n && (frame_valid || bad_code)) begin
            got = '{value: value, dp: dp, frame: frame_valid, bad: bad_code};
            total_cnt++;
            if (sb.size() == 0) begin
                bad_cnt++;
                $display("[TB] FAIL unexpected_pulse got value=%h dp=%b fv=%b bad=%b required no pulse",
                         got.value, got.dp, got.frame, got.bad);
            end else begin
                want = sb.pop_front();
                if (got !== want) begin
                    bad_cnt++;
                    $display("[TB] FAIL pulse_event got value=%h dp=%b fv=%b bad=%b required value=%h dp=%b fv=%b bad=%b",
                             got.value, got.dp, got.frame, got.bad,
                             want.value, want.dp, want.frame, want.bad);
                end
            end
        end
    end

    task automatic applyStimulus(input logic [3:0] d, input logic [7:0] s, input int cycles);
        digits   = d;
        segments = s;
        repeat (cycles) @(negedge clk);
    endtask

    task automatic checkOutput(input string name, input logic [15:0] actual, input logic [15:0] expected);
        total_cnt++;
        if (actual !== expected) begin
            bad_cnt++;
            $display("[TB] FAIL %s got=%h required=%h", name, actual, expected);
        end
    endtask

    task automatic expectPulse(input logic [15:0] v, input logic [3:0] d, input logic f, input logic b);
        sb.push_back('{value: v, dp: d, frame: f, bad: b});
    endtask

    task automatic scanOnce();
        applyStimulus(4'b1110, 8'h4F, 256);
        applyStimulus(4'b1101, 8'h4F, 256);
        applyStimulus(4'b1011, 8'h7D, 256);
        expectPulse(16'h3633, 4'b0000, 1'b1, 1'b0);
        applyStimulus(4'b0111, 8'h4F, 256);
        checkOutput("scan_value", value, 16'h3633);
    endtask

    initial begin
        rst_n    = 1'b0;
        digits   = 4'b1111;
        segments = 8'h00;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        checkOutput("reset_value", value, 16'hFFFF);
        checkOutput("reset_dp", {12'd0, dp}, 16'd0);
        checkOutput("reset_fv", {15'd0, frame_valid}, 16'd0);
        checkOutput("reset_bad", {15'd0, bad_code}, 16'd0);
        checkOutput("reset_stale", {15'd0, stale}, 16'd0);

        applyStimulus(4'b1110, 8'h4F, 10);
        checkOutput("pos0_three", value, 16'hFFF3);
        checkOutput("pos0_dp", {12'd0, dp}, 16'd0);

        applyStimulus(4'b1101, 8'h06, 2);
        applyStimulus(4'b1101, 8'h5B, 12);
        checkOutput("short_hold", value, 16'hFF23);

        expectPulse(16'hFE23, 4'b0000, 1'b0, 1'b1);
        applyStimulus(4'b1011, 8'h49, 12);
        checkOutput("bad_pattern", value, 16'hFE23);
        applyStimulus(4'b1100, 8'h7F, 12);
        checkOutput("multi_zero", value, 16'hFE23);
        expectPulse(16'h3E23, 4'b1000, 1'b1, 1'b0);
        applyStimulus(4'b0111, 8'hCF, 12);
        checkOutput("dp_frame_value", value, 16'h3E23);
        checkOutput("dp_frame_dp", {12'd0, dp}, 16'h0008);

        scanOnce();
        scanOnce();

        applyStimulus(4'b1110, 8'h06, 12);
        checkOutput("repeat_first", value, 16'h3631);
        applyStimulus(4'b1110, 8'h5B, 12);
        checkOutput("repeat_overwrite", value, 16'h3632);
        applyStimulus(4'b1101, 8'h3F, 12);
        applyStimulus(4'b1011, 8'h00, 12);
        checkOutput("blank_code", value, 16'h3F02);
        expectPulse(16'h8F02, 4'b0000, 1'b1, 1'b0);
        applyStimulus(4'b0111, 8'h7F, 12);
        checkOutput("repeat_frame", value, 16'h8F02);

        applyStimulus(4'b1110, 8'h3F, 12);
        applyStimulus(4'b1101, 8'h3F, 12);
        applyStimulus(4'b1011, 8'h3F, 12);
        expectPulse(16'hE000, 4'b0000, 1'b1, 1'b1);
        applyStimulus(4'b0111, 8'h49, 12);
        checkOutput("bad_and_frame", value, 16'hE000);

        applyStimulus(4'b1110, 8'h06, 12);
        applyStimulus(4'b1101, 8'h06, 12);
        applyStimulus(4'b1011, 8'h06, 12);
        checkOutput("partial_frame", value, 16'hE111);
        digits   = 4'b1111;
        segments = 8'h00;
        rst_n    = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        checkOutput("midreset_value", value, 16'hFFFF);
        checkOutput("midreset_dp", {12'd0, dp}, 16'd0);

        repeat (4090) @(negedge clk);
        checkOutput("stale_before", {15'd0, stale}, 16'd0);
        repeat (10) @(negedge clk);
        checkOutput("stale_after", {15'd0, stale}, 16'd1);

        applyStimulus(4'b0111, 8'h6D, 12);
        checkOutput("stale_cleared", {15'd0, stale}, 16'd0);
        checkOutput("fresh_pos3", value, 16'h5FFF);
        applyStimulus(4'b1110, 8'h6F, 12);
        applyStimulus(4'b1101, 8'h07, 12);
        expectPulse(16'h5479, 4'b0000, 1'b1, 1'b0);
        applyStimulus(4'b1011, 8'h66, 12);
        checkOutput("fresh_frame", value, 16'h5479);

        applyStimulus(4'b1111, 8'h00, 10);
        checkOutput("scoreboard_drained", 16'(sb.size()), 16'd0);

        $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
        $finish;
    end

endmodule
